// File: rtl/srt_div_sched_pkg.sv
// Shared definitions for the SRT divider scheduler: FSM encoding, response codes
// and the divisor screening rule of the shared core.
package srt_div_sched_pkg;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CLR     = 3'd1;
  localparam logic [2:0] S_LAUNCH  = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_CAPTURE = 3'd4;
  localparam logic [2:0] S_RESP    = 3'd5;

  localparam logic [1:0] RSP_OK    = 2'b00;
  localparam logic [1:0] RSP_DIV0  = 2'b01;
  localparam logic [1:0] RSP_RANGE = 2'b10;

  localparam logic [7:0] D_MIN = 8'd64;
  localparam logic [7:0] D_MAX = 8'd128;

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] r;
    logic [1:0] err;
  } rsp_t;

  // The core only handles normalised divisors, D[7:3] in 01000..10000.
  function automatic logic [1:0] screen_d(input logic [7:0] d);
    if (d == 8'd0)
      return RSP_DIV0;
    else if (d < D_MIN || d > D_MAX)
      return RSP_RANGE;
    else
      return RSP_OK;
  endfunction

endpackage

// File: rtl/srt_div_sched_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first valid requester at or
// after the pointer, wrapping around.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] i_valid,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_idx,
  output logic            o_any
);

  int             w_sum;
  logic [IDW-1:0] w_j;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_sum   = 0;
    w_j     = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum = int'(i_ptr) + k;
      if (w_sum >= NREQ)
        w_sum = w_sum - NREQ;
      w_j = IDW'(w_sum);
      if (!o_any && i_valid[w_j]) begin
        o_any      = 1'b1;
        o_grant[w_j] = 1'b1;
        o_idx      = w_j;
      end
    end
  end

endmodule

// File: rtl/srt_div_sched.sv
// Shares one radix-4 SRT divider core among NREQ requesters: round-robin grant,
// divisor screening, per-operation core re-arm and fixed-latency capture.
module srt_div_sched
  import srt_div_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DIV_LAT = 7,
  parameter int IDW     = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NREQ-1:0]   i_req_valid,
  output logic [NREQ-1:0]   o_req_ready,
  input  logic [8*NREQ-1:0] i_req_n,
  input  logic [8*NREQ-1:0] i_req_d,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [IDW-1:0]    o_rsp_id,
  output logic [7:0]        o_rsp_q,
  output logic [7:0]        o_rsp_r,
  output logic [1:0]        o_rsp_err,
  output logic              o_div_resetn,
  output logic              o_div_enable,
  output logic [7:0]        o_div_n,
  output logic [7:0]        o_div_d,
  input  logic [7:0]        i_div_q,
  input  logic [7:0]        i_div_r,
  output logic              o_busy
);

  localparam int CW = $clog2(DIV_LAT) + 1;

  logic [2:0]     r_state;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] r_id;
  logic [7:0]     r_n;
  logic [7:0]     r_d;
  logic [CW-1:0]  r_cnt;
  rsp_t           r_rsp;

  logic [NREQ-1:0] w_grant;
  logic [IDW-1:0]  w_idx;
  logic            w_any;
  logic [7:0]      w_sel_n;
  logic [7:0]      w_sel_d;
  logic [1:0]      w_screen;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .i_valid (i_req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_sel_n  = i_req_n[8*w_idx +: 8];
  assign w_sel_d  = i_req_d[8*w_idx +: 8];
  assign w_screen = screen_d(w_sel_d);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_id    <= '0;
      r_n     <= '0;
      r_d     <= '0;
      r_cnt   <= '0;
      r_rsp   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_ptr <= (w_idx == IDW'(NREQ-1)) ? '0 : w_idx + 1'b1;
            r_id  <= w_idx;
            case (w_screen)
              RSP_DIV0: begin
                r_rsp   <= '{q: 8'hFF, r: w_sel_n, err: RSP_DIV0};
                r_state <= S_RESP;
              end
              RSP_RANGE: begin
                r_rsp   <= '{q: 8'h00, r: 8'h00, err: RSP_RANGE};
                r_state <= S_RESP;
              end
              default: begin
                r_n     <= w_sel_n;
                r_d     <= w_sel_d;
                r_state <= S_CLR;
              end
            endcase
          end
        end
        // The LAUNCH cycle counts as the first latency cycle.
        S_CLR: begin
          r_cnt   <= CW'(DIV_LAT - 1);
          r_state <= S_LAUNCH;
        end
        S_LAUNCH: begin
          if (r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt == '0)
            r_state <= S_CAPTURE;
          else
            r_cnt <= r_cnt - 1'b1;
        end
        S_CAPTURE: begin
          r_rsp   <= '{q: i_div_q, r: i_div_r, err: RSP_OK};
          r_state <= S_RESP;
        end
        S_RESP: begin
          if (i_rsp_ready)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Control outputs are qualified by resetn so the core is held in reset and
  // any pending response vanishes as soon as reset is asserted.
  assign o_req_ready  = (resetn && r_state == S_IDLE) ? w_grant : '0;
  assign o_rsp_valid  = resetn && (r_state == S_RESP);
  assign o_busy       = resetn && (r_state != S_IDLE);
  assign o_div_resetn = resetn && (r_state != S_CLR);
  assign o_div_enable = resetn && (r_state == S_LAUNCH);
  assign o_div_n      = r_n;
  assign o_div_d      = r_d;
  assign o_rsp_id     = r_id;
  assign o_rsp_q      = r_rsp.q;
  assign o_rsp_r      = r_rsp.r;
  assign o_rsp_err    = r_rsp.err;

endmodule

// File: tb/tb_srt_div_sched.sv
// Scoreboard bench for srt_div_sched with a behavioural fixed-latency divider core.
module tb_srt_div_sched;

  localparam int NREQ    = 4;
  localparam int DIV_LAT = 7;
  localparam int IDW     = 2;

  logic              clk;
  logic              resetn;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [8*NREQ-1:0] req_n;
  logic [8*NREQ-1:0] req_d;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [7:0]        rsp_q;
  logic [7:0]        rsp_r;
  logic [1:0]        rsp_err;
  logic              div_resetn;
  logic              div_enable;
  logic [7:0]        div_n;
  logic [7:0]        div_d;
  logic [7:0]        div_q;
  logic [7:0]        div_r;
  logic              busy;

  srt_div_sched #(.NREQ(NREQ), .DIV_LAT(DIV_LAT), .IDW(IDW)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_n      (req_n),
    .i_req_d      (req_d),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_rsp_id     (rsp_id),
    .o_rsp_q      (rsp_q),
    .o_rsp_r      (rsp_r),
    .o_rsp_err    (rsp_err),
    .o_div_resetn (div_resetn),
    .o_div_enable (div_enable),
    .o_div_n      (div_n),
    .o_div_d      (div_d),
    .i_div_q      (div_q),
    .i_div_r      (div_r),
    .o_busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int id;
    int q;
    int r;
    int err;
    int lat;
    int t0;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;
  int   en_cnt   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic exp_t model(input int id, input logic [7:0] n, input logic [7:0] d, input int t);
    exp_t e;
    e.id = id;
    e.t0 = t;
    if (d == 8'd0) begin
      e.err = 1; e.q = 8'hFF; e.r = int'(n); e.lat = 1;
    end else if (d < 8'd64 || d > 8'd128) begin
      e.err = 2; e.q = 0; e.r = 0; e.lat = 1;
    end else begin
      e.err = 0; e.q = int'(n) / int'(d); e.r = int'(n) % int'(d); e.lat = DIV_LAT + 3;
    end
    return e;
  endfunction

  // Divider core: results valid DIV_LAT cycles after enable, garbage otherwise;
  // operands that move mid-operation corrupt the result.
  logic       core_vld;
  int         core_cnt;
  logic [7:0] en_n, en_d, core_q, core_r;

  always @(posedge clk) begin
    if (!div_resetn) begin
      core_vld <= 1'b0;
      core_cnt <= 0;
    end else if (div_enable) begin
      core_vld <= 1'b0;
      core_cnt <= DIV_LAT - 1;
      en_n     <= div_n;
      en_d     <= div_d;
    end else if (core_cnt != 0) begin
      core_cnt <= core_cnt - 1;
      if (core_cnt == 1) begin
        core_vld <= 1'b1;
        if (div_n == en_n && div_d == en_d && en_d != 8'd0) begin
          core_q <= en_n / en_d;
          core_r <= en_n % en_d;
        end else begin
          core_q <= 8'hEE;
          core_r <= 8'hEE;
        end
      end
    end
  end

  assign div_q = core_vld ? core_q : 8'hA5;
  assign div_r = core_vld ? core_r : 8'h5A;

  // Monitor: scoreboard push on accept, pop on transfer, protocol checks.
  initial begin
    logic            prev_rv, prev_rr, prev_dr;
    logic [NREQ-1:0] prev_rdy;
    logic [19:0]     prev_pk;
    exp_t            e;
    prev_rv = 1'b0; prev_rr = 1'b0; prev_dr = 1'b0; prev_rdy = '0; prev_pk = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!resetn) begin
        sb.delete();
        prev_rv = 1'b0; prev_rr = 1'b0; prev_rdy = '0;
      end else begin
        if (req_ready != '0) begin
          check("rdy_onehot", $countones(req_ready), 1);
          check("rdy_pulse", req_ready & prev_rdy, 0);
          check("rdy_not_busy", busy, 0);
          for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
              check("rdy_needs_valid", req_valid[i], 1);
              if (req_valid[i]) begin
                sb.push_back(model(i, req_n[8*i +: 8], req_d[8*i +: 8], cyc));
                grant_log.push_back(i);
              end
            end
          end
        end
        if (div_enable) begin
          en_cnt++;
          check("core_reset_before_enable", prev_dr, 0);
        end
        if (rsp_valid && !prev_rv) begin
          check("sb_size_at_rsp", 32'(sb.size()), 1);
          if (sb.size() != 0)
            check("latency", cyc - sb[0].t0, sb[0].lat);
        end
        if (prev_rv && !prev_rr) begin
          check("rsp_hold_valid", rsp_valid, 1);
          check("rsp_hold_data", {rsp_id, rsp_q, rsp_r, rsp_err}, prev_pk);
        end
        if (rsp_valid && rsp_ready) begin
          check("sb_size_at_pop", 32'(sb.size()), 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("rsp_id", rsp_id, e.id);
            check("rsp_q", rsp_q, e.q);
            check("rsp_r", rsp_r, e.r);
            check("rsp_err", rsp_err, e.err);
          end
        end
        prev_rv  = rsp_valid;
        prev_rr  = rsp_ready;
        prev_rdy = req_ready;
      end
      prev_dr = div_resetn;
      prev_pk = {rsp_id, rsp_q, rsp_r, rsp_err};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic [7:0] n, input logic [7:0] d);
    req_n[8*id +: 8] = n;
    req_d[8*id +: 8] = d;
    req_valid[id]    = 1'b1;
  endtask

  task automatic wait_grant(input int id);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (req_ready[id]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok)
      check("grant_timeout", req_ready[id], 1);
    tick();
  endtask

  task automatic do_req(input int id, input logic [7:0] n, input logic [7:0] d);
    set_req(id, n, d);
    wait_grant(id);
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok)
      check("idle_timeout", busy, 0);
    tick();
  endtask

  task automatic check_reset_outputs();
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_q", rsp_q, 0);
    check("rst_rsp_r", rsp_r, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_div_enable", div_enable, 0);
    check("rst_div_resetn", div_resetn, 0);
    check("rst_div_n", div_n, 0);
    check("rst_div_d", div_d, 0);
    check("rst_busy", busy, 0);
  endtask

  initial begin
    int  t;
    bit  ok;
    resetn    = 1'b0;
    req_valid = '0;
    req_n     = '0;
    req_d     = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    tick();
    resetn = 1'b1;
    tick();

    // All requesters valid continuously: round-robin order from pointer 0.
    for (int i = 0; i < NREQ; i++)
      set_req(i, 8'(60 + 45 * i), 8'(64 + 20 * i));
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (grant_log.size() >= 5) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
    req_valid = '0;
    check("order_grant_count", 32'(grant_log.size()), 5);
    if (ok)
      for (int k = 0; k < 5; k++)
        check("grant_order", grant_log[k], k % NREQ);
    wait_idle();

    // Single core operation on id1.
    t = en_cnt;
    do_req(1, 8'd100, 8'd80);
    wait_idle();
    check("id1_core_started", en_cnt - t, 1);

    // Divide by zero and out-of-range divisors never start the core.
    t = en_cnt;
    do_req(2, 8'd37, 8'd0);
    wait_idle();
    check("div0_no_enable", en_cnt, t);
    do_req(0, 8'd55, 8'd200);
    do_req(3, 8'd9, 8'd20);
    wait_idle();
    check("range_no_enable", en_cnt, t);

    // Back-pressure in RESP with another requester waiting.
    rsp_ready = 1'b0;
    set_req(1, 8'd250, 8'd100);
    wait_grant(1);
    req_valid[1] = 1'b0;
    set_req(0, 8'd200, 8'd128);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok)
      check("bp_rsp_timeout", rsp_valid, 1);
    for (int k = 0; k < 10; k++) begin
      check("bp_no_grant", req_ready, 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    wait_grant(0);
    req_valid[0] = 1'b0;
    wait_idle();

    // Reset during WAIT, then round-robin restarts from pointer 0.
    set_req(2, 8'd90, 8'd70);
    wait_grant(2);
    req_valid[2] = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (div_enable) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok)
      check("launch_timeout", div_enable, 1);
    tick();
    tick();
    resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    tick();
    resetn = 1'b1;
    tick();
    set_req(1, 8'd77, 8'd77);
    set_req(3, 8'd10, 8'd64);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        ok = 1'b1;
        break;
      end
    end
    check("post_rst_grant", req_ready, 4'b0010);
    tick();
    req_valid[1] = 1'b0;
    wait_grant(3);
    req_valid[3] = 1'b0;
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1);
  end

endmodule
